tl_sram_responder: RTL and testbench



---
 rtl/tl_pkg.sv | 30 +++
 rtl/tl_sram_array.sv | 28 ++
 rtl/tl_sram_responder.sv | 197 +++++++++++++++++++
 tb/tb_tl_sram_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - TileLink-UL opcodes, responder FSM states and beat-count helper
package tl_pkg;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;

    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        IDLE,
        PUT,
        RESP
    } state_t;

    // Index of the last beat of a message (beats - 1) on a 64-bit link.
    // Sizes above 6 are illegal and get denied; they wrap to 7 so such a
    // message still drains/answers a bounded 8 beats.
    function automatic logic [2:0] beats_minus_one(input logic [2:0] size);
        logic [4:0] beats;
        if (size <= 3'd3) begin
            beats_minus_one = 3'd0;
        end else begin
            beats = 5'd1 << (size - 3'd3);
            beats_minus_one = 3'(beats - 5'd1);
        end
    endfunction

endpackage

// File: rtl/tl_sram_array.sv
// rtl/tl_sram_array.sv - 64-bit word flop array, byte-masked write, registered read
// Ports: clock; wr_en/wr_addr/wr_mask/wr_data write port (one word per cycle);
//        rd_addr in, rd_data out one cycle later. Contents are not reset.
module tl_sram_array #(
    parameter int DEPTH_WORDS = 512,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_mask,
    input  logic [63:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [63:0]   rd_data
);

    logic [63:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        for (int b = 0; b < 8; b++) begin
            if (wr_en && wr_mask[b]) begin
                mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/tl_sram_responder.sv
// rtl/tl_sram_responder.sv - TileLink-UL manager endpoint serving a 64-bit A/D link from a flop array
// Ports: clock, reset (sync, active-high);
//        auto_in_a_* : A channel request (opcode/param/size/source/address/mask/data/corrupt);
//        auto_in_d_* : D channel response (opcode/size/source/denied/data/corrupt).
module tl_sram_responder
    import tl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 512
) (
    input  logic        clock,
    input  logic        reset,
    output logic        auto_in_a_ready,
    input  logic        auto_in_a_valid,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [2:0]  auto_in_a_bits_size,
    input  logic [3:0]  auto_in_a_bits_source,
    input  logic [31:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    input  logic        auto_in_a_bits_corrupt,
    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [2:0]  auto_in_d_bits_size,
    output logic [3:0]  auto_in_d_bits_source,
    output logic        auto_in_d_bits_denied,
    output logic [63:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_corrupt
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd8;

    state_t        state, state_next;
    logic [2:0]    beat_cnt, beat_next;
    logic          started;

    logic [2:0]    req_opcode;
    logic [2:0]    req_size;
    logic [3:0]    req_source;
    logic          req_denied;
    logic [2:0]    req_last;
    logic [AW-1:0] req_word;

    logic          latch_req;
    logic          out_en;
    logic          a_fire;
    logic          d_fire;
    logic          is_get;

    logic [31:0]   a_off;
    logic [AW-1:0] a_word;
    logic [32:0]   a_end;
    logic          a_denied;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [63:0]   rd_data;

    logic          unused_bits;

    // Address decode of the incoming first beat; 33-bit end address so a
    // request running past the top of the 32-bit space is still caught.
    assign a_off    = auto_in_a_bits_address - BASE_ADDR;
    assign a_word   = a_off[AW+2:3];
    assign a_end    = {1'b0, auto_in_a_bits_address} + (33'd1 << auto_in_a_bits_size);
    assign a_denied = (auto_in_a_bits_address < BASE_ADDR) ||
                      (a_end > LIMIT) ||
                      (auto_in_a_bits_size > 3'd6) ||
                      !((auto_in_a_bits_opcode == PUT_FULL) ||
                        (auto_in_a_bits_opcode == PUT_PARTIAL) ||
                        (auto_in_a_bits_opcode == GET));

    assign unused_bits = ^{auto_in_a_bits_param, a_off[31:AW+3], a_off[2:0]};

    // Outputs stay quiet while reset is asserted and for the first cycle after.
    assign out_en = started && !reset;
    assign a_fire = auto_in_a_ready && auto_in_a_valid;
    assign d_fire = auto_in_d_valid && auto_in_d_ready;
    assign is_get = (req_opcode == GET);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            beat_cnt <= 3'd0;
            started  <= 1'b0;
        end else begin
            state    <= state_next;
            beat_cnt <= beat_next;
            started  <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            req_opcode <= 3'd0;
            req_size   <= 3'd0;
            req_source <= 4'd0;
            req_denied <= 1'b0;
            req_last   <= 3'd0;
            req_word   <= '0;
        end else if (latch_req) begin
            req_opcode <= auto_in_a_bits_opcode;
            req_size   <= auto_in_a_bits_size;
            req_source <= auto_in_a_bits_source;
            req_denied <= a_denied;
            req_last   <= beats_minus_one(auto_in_a_bits_size);
            req_word   <= a_word;
        end
    end

    always_comb begin
        state_next      = state;
        beat_next       = beat_cnt;
        latch_req       = 1'b0;
        wr_en           = 1'b0;
        wr_addr         = req_word + AW'(beat_cnt);
        rd_addr         = req_word + AW'(beat_cnt);
        auto_in_a_ready = 1'b0;
        auto_in_d_valid = 1'b0;
        case (state)
            IDLE: begin
                auto_in_a_ready = out_en;
                // Present beat 0 so the first response word is ready next cycle.
                rd_addr = a_word;
                if (a_fire) begin
                    latch_req = 1'b1;
                    beat_next = 3'd0;
                    if (auto_in_a_bits_opcode[2]) begin
                        state_next = RESP;
                    end else begin
                        wr_en   = !a_denied && !auto_in_a_bits_corrupt;
                        wr_addr = a_word;
                        if (beats_minus_one(auto_in_a_bits_size) == 3'd0) begin
                            state_next = RESP;
                        end else begin
                            state_next = PUT;
                            beat_next  = 3'd1;
                        end
                    end
                end
            end
            PUT: begin
                auto_in_a_ready = out_en;
                if (a_fire) begin
                    wr_en = !req_denied && !auto_in_a_bits_corrupt;
                    if (beat_cnt == req_last) begin
                        state_next = RESP;
                        beat_next  = 3'd0;
                    end else begin
                        beat_next = beat_cnt + 3'd1;
                    end
                end
            end
            RESP: begin
                auto_in_d_valid = out_en;
                if (d_fire) begin
                    if (is_get && (beat_cnt != req_last)) begin
                        beat_next = beat_cnt + 3'd1;
                        // Fetch the following word so it lands as the next beat.
                        rd_addr   = req_word + AW'(beat_cnt) + AW'(1);
                    end else begin
                        state_next = IDLE;
                        beat_next  = 3'd0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign auto_in_d_bits_opcode  = auto_in_d_valid ? (is_get ? ACCESS_ACK_DATA : ACCESS_ACK) : 3'd0;
    assign auto_in_d_bits_size    = auto_in_d_valid ? req_size : 3'd0;
    assign auto_in_d_bits_source  = auto_in_d_valid ? req_source : 4'd0;
    assign auto_in_d_bits_denied  = auto_in_d_valid && req_denied;
    assign auto_in_d_bits_corrupt = auto_in_d_valid && is_get && req_denied;
    assign auto_in_d_bits_data    = (auto_in_d_valid && is_get && !req_denied) ? rd_data : 64'd0;

    tl_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_mask (auto_in_a_bits_mask),
        .wr_data (auto_in_a_bits_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_tl_sram_responder.sv
// tb/tb_tl_sram_responder.sv - directed self-checking bench for tl_sram_responder
module tb_tl_sram_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_ready;
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        a_corrupt;
    logic        d_ready;
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_size;
    logic [3:0]  d_source;
    logic        d_denied;
    logic [63:0] d_data;
    logic        d_corrupt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    tl_sram_responder dut (
        .clock                  (clock),
        .reset                  (reset),
        .auto_in_a_ready        (a_ready),
        .auto_in_a_valid        (a_valid),
        .auto_in_a_bits_opcode  (a_opcode),
        .auto_in_a_bits_param   (a_param),
        .auto_in_a_bits_size    (a_size),
        .auto_in_a_bits_source  (a_source),
        .auto_in_a_bits_address (a_address),
        .auto_in_a_bits_mask    (a_mask),
        .auto_in_a_bits_data    (a_data),
        .auto_in_a_bits_corrupt (a_corrupt),
        .auto_in_d_ready        (d_ready),
        .auto_in_d_valid        (d_valid),
        .auto_in_d_bits_opcode  (d_opcode),
        .auto_in_d_bits_size    (d_size),
        .auto_in_d_bits_source  (d_source),
        .auto_in_d_bits_denied  (d_denied),
        .auto_in_d_bits_data    (d_data),
        .auto_in_d_bits_corrupt (d_corrupt)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Starts and ends at a negedge; holds the beat until a_ready is seen.
    task automatic send_a(input string tag, input logic [2:0] op, input logic [2:0] size,
                          input logic [3:0] src, input logic [31:0] addr, input logic [7:0] mask,
                          input logic [63:0] data, input logic corrupt);
        int n;
        a_opcode  = op;
        a_size    = size;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_corrupt = corrupt;
        a_valid   = 1'b1;
        n = 0;
        while (a_ready !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check_eq({tag, "_a_ready"}, 64'(a_ready), 64'd1);
        @(negedge clock);
        a_valid   = 1'b0;
        a_corrupt = 1'b0;
    endtask

    // Waits for one D beat, checks it, optionally stalls a cycle, then accepts it.
    task automatic recv_d(input string tag, input logic [2:0] op, input logic [2:0] size,
                          input logic [3:0] src, input logic denied, input logic [63:0] data,
                          input logic corrupt, input logic stall);
        int n;
        logic [11:0] exp_meta;
        exp_meta = {op, size, src, denied, corrupt};
        n = 0;
        while (d_valid !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check_eq({tag, "_d_valid"}, 64'(d_valid), 64'd1);
        check_eq({tag, "_meta"}, 64'({d_opcode, d_size, d_source, d_denied, d_corrupt}), 64'(exp_meta));
        check_eq({tag, "_data"}, d_data, data);
        if (stall) begin
            d_ready = 1'b0;
            @(negedge clock);
            check_eq({tag, "_hold_valid"}, 64'(d_valid), 64'd1);
            check_eq({tag, "_hold_meta"}, 64'({d_opcode, d_size, d_source, d_denied, d_corrupt}), 64'(exp_meta));
            check_eq({tag, "_hold_data"}, d_data, data);
        end
        d_ready = 1'b1;
        check_eq({tag, "_a_ready_in_resp"}, 64'(a_ready), 64'd0);
        @(negedge clock);
        d_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        a_valid   = 1'b0;
        a_opcode  = 3'd0;
        a_param   = 3'd0;
        a_size    = 3'd0;
        a_source  = 4'd0;
        a_address = 32'd0;
        a_mask    = 8'd0;
        a_data    = 64'd0;
        a_corrupt = 1'b0;
        d_ready   = 1'b0;

        // Reset and the quiet cycle after it.
        repeat (3) @(negedge clock);
        check_eq("rst_a_ready", 64'(a_ready), 64'd0);
        check_eq("rst_d_valid", 64'(d_valid), 64'd0);
        check_eq("rst_d_meta", 64'({d_opcode, d_size, d_source, d_denied, d_corrupt}), 64'd0);
        check_eq("rst_d_data", d_data, 64'd0);
        reset = 1'b0;
        check_eq("post_rst_a_ready", 64'(a_ready), 64'd0);
        check_eq("post_rst_d_valid", 64'(d_valid), 64'd0);
        @(negedge clock);
        check_eq("idle_a_ready", 64'(a_ready), 64'd1);

        // PutFull / Get of one word.
        send_a("put0", 3'd0, 3'd3, 4'd3, 32'h8000_0000, 8'hFF, 64'h1122_3344_5566_7788, 1'b0);
        check_eq("put_ack_latency", 64'(d_valid), 64'd1);
        recv_d("put0_ack", 3'd0, 3'd3, 4'd3, 1'b0, 64'd0, 1'b0, 1'b0);
        check_eq("turnaround_d_valid", 64'(d_valid), 64'd0);
        check_eq("turnaround_a_ready", 64'(a_ready), 64'd1);
        send_a("get0", 3'd4, 3'd3, 4'd5, 32'h8000_0000, 8'h00, 64'd0, 1'b0);
        check_eq("get_latency", 64'(d_valid), 64'd1);
        recv_d("get0_d", 3'd1, 3'd3, 4'd5, 1'b0, 64'h1122_3344_5566_7788, 1'b0, 1'b0);

        // PutPartial low four bytes.
        send_a("pp", 3'd1, 3'd3, 4'd1, 32'h8000_0000, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        recv_d("pp_ack", 3'd0, 3'd3, 4'd1, 1'b0, 64'd0, 1'b0, 1'b0);
        send_a("get_pp", 3'd4, 3'd3, 4'd2, 32'h8000_0000, 8'h00, 64'd0, 1'b0);
        recv_d("get_pp_d", 3'd1, 3'd3, 4'd2, 1'b0, 64'h1122_3344_FFFF_FFFF, 1'b0, 1'b0);

        // Corrupt beat must not overwrite.
        send_a("put1", 3'd0, 3'd3, 4'd4, 32'h8000_0008, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0);
        recv_d("put1_ack", 3'd0, 3'd3, 4'd4, 1'b0, 64'd0, 1'b0, 1'b0);
        send_a("put_corrupt", 3'd0, 3'd3, 4'd4, 32'h8000_0008, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1);
        recv_d("put_corrupt_ack", 3'd0, 3'd3, 4'd4, 1'b0, 64'd0, 1'b0, 1'b0);
        send_a("get1", 3'd4, 3'd3, 4'd6, 32'h8000_0008, 8'h00, 64'd0, 1'b0);
        recv_d("get1_d", 3'd1, 3'd3, 4'd6, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);

        // 64-byte burst write then stalled burst read.
        for (int k = 0; k < 8; k++) begin
            send_a($sformatf("burst_put%0d", k), 3'd0, 3'd6, 4'd7, 32'h8000_0040, 8'hFF, 64'(k), 1'b0);
            if (k < 7) check_eq($sformatf("burst_put%0d_no_ack", k), 64'(d_valid), 64'd0);
        end
        recv_d("burst_put_ack", 3'd0, 3'd6, 4'd7, 1'b0, 64'd0, 1'b0, 1'b0);
        send_a("burst_get", 3'd4, 3'd6, 4'd8, 32'h8000_0040, 8'h00, 64'd0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            recv_d($sformatf("burst_get%0d", k), 3'd1, 3'd6, 4'd8, 1'b0, 64'(k), 1'b0, 1'b1);
        end
        check_eq("burst_get_done", 64'(d_valid), 64'd0);

        // Last in-range word.
        send_a("put_top", 3'd0, 3'd3, 4'd9, 32'h8000_0FF8, 8'hFF, 64'hCAFE_F00D_1234_5678, 1'b0);
        recv_d("put_top_ack", 3'd0, 3'd3, 4'd9, 1'b0, 64'd0, 1'b0, 1'b0);
        send_a("get_top", 3'd4, 3'd3, 4'd9, 32'h8000_0FF8, 8'h00, 64'd0, 1'b0);
        recv_d("get_top_d", 3'd1, 3'd3, 4'd9, 1'b0, 64'hCAFE_F00D_1234_5678, 1'b0, 1'b0);

        // Out-of-range requests.
        send_a("put_oor", 3'd0, 3'd3, 4'd10, 32'h8000_1000, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD, 1'b0);
        recv_d("put_oor_ack", 3'd0, 3'd3, 4'd10, 1'b1, 64'd0, 1'b0, 1'b0);
        send_a("get_low", 3'd4, 3'd3, 4'd11, 32'h7FFF_FFF8, 8'h00, 64'd0, 1'b0);
        recv_d("get_low_d", 3'd1, 3'd3, 4'd11, 1'b1, 64'd0, 1'b1, 1'b0);
        check_eq("get_low_single", 64'(d_valid), 64'd0);
        send_a("get_high", 3'd4, 3'd6, 4'd12, 32'h8000_0FE0, 8'h00, 64'd0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            recv_d($sformatf("get_high%0d", k), 3'd1, 3'd6, 4'd12, 1'b1, 64'd0, 1'b1, 1'b0);
        end
        check_eq("get_high_done", 64'(d_valid), 64'd0);
        send_a("get_keep", 3'd4, 3'd4, 4'd13, 32'h8000_0000, 8'h00, 64'd0, 1'b0);
        recv_d("get_keep0", 3'd1, 3'd4, 4'd13, 1'b0, 64'h1122_3344_FFFF_FFFF, 1'b0, 1'b0);
        recv_d("get_keep1", 3'd1, 3'd4, 4'd13, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);

        // Unsupported opcodes.
        send_a("hint", 3'd5, 3'd3, 4'd14, 32'h8000_0000, 8'hFF, 64'd0, 1'b0);
        recv_d("hint_ack", 3'd0, 3'd3, 4'd14, 1'b1, 64'd0, 1'b0, 1'b0);
        check_eq("hint_single", 64'(d_valid), 64'd0);
        send_a("op2_b0", 3'd2, 3'd4, 4'd15, 32'h8000_0000, 8'hFF, 64'h5555_5555_5555_5555, 1'b0);
        check_eq("op2_no_early_ack", 64'(d_valid), 64'd0);
        send_a("op2_b1", 3'd2, 3'd4, 4'd15, 32'h8000_0000, 8'hFF, 64'h5555_5555_5555_5555, 1'b0);
        recv_d("op2_ack", 3'd0, 3'd4, 4'd15, 1'b1, 64'd0, 1'b0, 1'b0);
        check_eq("op2_single", 64'(d_valid), 64'd0);
        send_a("get_after_op2", 3'd4, 3'd3, 4'd1, 32'h8000_0000, 8'h00, 64'd0, 1'b0);
        recv_d("get_after_op2_d", 3'd1, 3'd3, 4'd1, 1'b0, 64'h1122_3344_FFFF_FFFF, 1'b0, 1'b0);

        // Reset in the middle of a burst read.
        send_a("rst_get", 3'd4, 3'd6, 4'd2, 32'h8000_0040, 8'h00, 64'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            recv_d($sformatf("rst_get%0d", k), 3'd1, 3'd6, 4'd2, 1'b0, 64'(k), 1'b0, 1'b0);
        end
        check_eq("rst_get_pending", 64'(d_valid), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        check_eq("mid_rst_d_valid", 64'(d_valid), 64'd0);
        check_eq("mid_rst_a_ready", 64'(a_ready), 64'd0);
        reset = 1'b0;
        check_eq("mid_post_rst_a_ready", 64'(a_ready), 64'd0);
        check_eq("mid_post_rst_d_valid", 64'(d_valid), 64'd0);
        @(negedge clock);
        check_eq("mid_rst_idle_a_ready", 64'(a_ready), 64'd1);
        check_eq("mid_rst_idle_d_valid", 64'(d_valid), 64'd0);
        send_a("fresh_get", 3'd4, 3'd3, 4'd3, 32'h8000_0058, 8'h00, 64'd0, 1'b0);
        recv_d("fresh_get_d", 3'd1, 3'd3, 4'd3, 1'b0, 64'd3, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
